lc4_pipe_ctrl: RTL and testbench
================================

LC4_PIPE_CTRL -- requirements
Module: lc4_pipe_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  main clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: gwe  input  1  global write enable (single-step); state advances only when high.
REQ-004 SHALL have ports: d_r1sel, d_r2sel  input  3 each  source register selects of the insn in Decode.
REQ-005 SHALL have ports: d_r1re, d_r2re, d_is_store, d_is_branch  input  1 each  Decode read enables and insn class.
REQ-006 SHALL have ports: x_is_load, x_regfile_we  input  1 each; x_wsel  input  3  Execute-stage insn info.
REQ-007 SHALL have port: x_redirect  input  1  Execute resolved a taken branch or control transfer.
REQ-008 SHALL have ports: pc_we, fd_we  output  1 each  write enables for the PC and F/D registers.
REQ-009 SHALL have ports: dx_bubble, fd_flush  output  1 each  insert NOP into D/X; replace F/D contents with NOP.
REQ-010 SHALL have ports: x_stall, m_stall, w_stall  output  2 each  stall code of the insn in X, M, W.
REQ-011 SHALL have port: test_stall  output  2  equals w_stall.
REQ-012 SHALL have ports: n_loaduse, n_flush  output  16 each  saturating event counters.

Function
REQ-013 Stall codes SHALL be: 0 normal, 2 flushed (branch or reset), 3 load-use bubble; 1 is reserved and never generated.
REQ-014 load_use SHALL be 1 iff x_is_load and x_regfile_we and either (d_r1re and d_r1sel==x_wsel), or (d_r2re and d_r2sel==x_wsel and not d_is_store), or d_is_branch.
REQ-015 Store data operands (r2 of a store) SHALL NOT cause a stall; WM bypass covers them.
REQ-016 If x_redirect=1: pc_we=1, fd_we=1, fd_flush=1, dx_bubble=1, regardless of load_use.
REQ-017 Else if load_use=1: pc_we=0, fd_we=0, fd_flush=0, dx_bubble=1.
REQ-018 Else: pc_we=1, fd_we=1, fd_flush=0, dx_bubble=0.
REQ-019 Outputs of REQ-016..018 SHALL be combinational from current inputs (zero latency).
REQ-020 Internal d_code (code of insn in D) SHALL update on gwe edge: 2 if x_redirect; hold if load_use; else 0.
REQ-021 x_stall SHALL update on gwe edge: 2 if x_redirect; else 3 if load_use; else d_code.
REQ-022 m_stall SHALL take x_stall, and w_stall SHALL take m_stall, on each gwe edge (one-cycle-per-stage pipe).
REQ-023 When gwe=0, all registered state SHALL hold; combinational outputs still track inputs.
REQ-024 n_loaduse SHALL increment on each gwe edge where load_use=1 and x_redirect=0; n_flush on each gwe edge where x_redirect=1.
REQ-025 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-026 Consecutive load_use cycles SHALL each insert one bubble and count once each.

Reset
REQ-027 On a rising clk edge with rst=1 (independent of gwe): d_code, x_stall, m_stall, w_stall SHALL become 2; counters SHALL become 0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override all update rules that cycle.
REQ-029 Combinational outputs are not masked by rst; the datapath resets its own registers.

Structure
REQ-030 Stall code constants (STALL_NONE=0, STALL_FLUSH=2, STALL_LOADUSE=3) SHALL live in shared package lc4_pipe_pkg.
REQ-031 Counters SHALL be two instances of sub-module lc4_sat_counter (16-bit, inc, clk/rst/gwe).
REQ-032 State registers SHALL use the codebase Nbit_reg with reset value parameter.

Verification
REQ-033 Reset: rst=1 one edge, then gwe pulses with no hazards -> w_stall 2,2,2 for three edges after reset, then 0; counters 0.
REQ-034 Load-use: x_is_load=1, x_regfile_we=1, x_wsel=3, d_r1re=1, d_r1sel=3 -> pc_we=0, fd_we=0, dx_bubble=1; x_stall=3 next edge, w_stall=3 two edges later; n_loaduse=1.
REQ-035 Store exemption: same but d_r1re=0, d_r2re=1, d_r2sel=3, d_is_store=1 -> no stall, pc_we=1, n_loaduse unchanged.
REQ-036 Simultaneous: load_use=1 and x_redirect=1 -> fd_flush=1, pc_we=1; x_stall=2; n_flush=1, n_loaduse unchanged.
REQ-037 gwe=0 for 5 clocks during load_use -> stall codes and counters unchanged.
REQ-038 Saturation: force 65540 load-use edges -> n_loaduse=16'hFFFF, stays there.

Source files
------------

// File: rtl/lc4_pipe_pkg.sv
// Shared definitions for the LC4 pipeline hazard controller.
// Stall codes travel with each instruction down the pipe.
package lc4_pipe_pkg;

    localparam logic [1:0] STALL_NONE    = 2'd0;
    localparam logic [1:0] STALL_FLUSH   = 2'd2;
    localparam logic [1:0] STALL_LOADUSE = 2'd3;

    localparam int CNT_W = 16;

    // Source operands that need a loaded value in D. A store's r2 is
    // excluded because the WM bypass supplies it.
    function automatic logic load_use_hit(
        input logic       x_is_load,
        input logic       x_regfile_we,
        input logic [2:0] x_wsel,
        input logic       d_r1re,
        input logic [2:0] d_r1sel,
        input logic       d_r2re,
        input logic [2:0] d_r2sel,
        input logic       d_is_store,
        input logic       d_is_branch
    );
        logic dep;
        dep = (d_r1re && (d_r1sel == x_wsel)) ||
              (d_r2re && (d_r2sel == x_wsel) && !d_is_store) ||
              d_is_branch;
        return x_is_load && x_regfile_we && dep;
    endfunction

endpackage

// File: rtl/Nbit_reg.sv
// Generic N-bit state register with write enable, global write enable
// and a parameterised synchronous reset value.
module Nbit_reg #(
    parameter int           n = 1,
    parameter logic [n-1:0] r = '0
) (
    input  logic [n-1:0] in,
    input  logic         clk,
    input  logic         we,
    input  logic         gwe,
    input  logic         rst,
    output logic [n-1:0] out
);

    logic [n-1:0] state_q;

    // Reset wins regardless of gwe so a single-stepped machine still resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= r;
        end else if (gwe && we) begin
            state_q <= in;
        end
    end

    assign out = state_q;

endmodule

// File: rtl/lc4_sat_counter.sv
// Saturating event counter; advances on gwe edges when inc is high and
// sticks at all-ones.
module lc4_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gwe,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (gwe) begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lc4_pipe_ctrl.sv
// LC4 five-stage pipeline hazard controller: load-use stall, branch flush,
// per-stage stall codes for the test interface, and event counters.
module lc4_pipe_ctrl
    import lc4_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        gwe,
    input  logic [2:0]  d_r1sel,
    input  logic [2:0]  d_r2sel,
    input  logic        d_r1re,
    input  logic        d_r2re,
    input  logic        d_is_store,
    input  logic        d_is_branch,
    input  logic        x_is_load,
    input  logic        x_regfile_we,
    input  logic [2:0]  x_wsel,
    input  logic        x_redirect,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_bubble,
    output logic        fd_flush,
    output logic [1:0]  x_stall,
    output logic [1:0]  m_stall,
    output logic [1:0]  w_stall,
    output logic [1:0]  test_stall,
    output logic [15:0] n_loaduse,
    output logic [15:0] n_flush
);

    logic       load_use;
    logic [1:0] d_code_q, d_code_d;
    logic [1:0] x_stall_q, x_stall_d;
    logic [1:0] m_stall_q, w_stall_q;

    assign load_use = load_use_hit(x_is_load, x_regfile_we, x_wsel,
                                   d_r1re, d_r1sel, d_r2re, d_r2sel,
                                   d_is_store, d_is_branch);

    // A redirect squashes both D and F, so it outranks a load-use stall.
    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        d_code_d  = STALL_NONE;
        x_stall_d = d_code_q;
        if (x_redirect) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            d_code_d  = STALL_FLUSH;
            x_stall_d = STALL_FLUSH;
        end else if (load_use) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_bubble = 1'b1;
            d_code_d  = d_code_q;
            x_stall_d = STALL_LOADUSE;
        end
    end

    Nbit_reg #(.n(2), .r(STALL_FLUSH)) u_d_code (
        .in(d_code_d), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst), .out(d_code_q)
    );

    Nbit_reg #(.n(2), .r(STALL_FLUSH)) u_x_stall (
        .in(x_stall_d), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst), .out(x_stall_q)
    );

    Nbit_reg #(.n(2), .r(STALL_FLUSH)) u_m_stall (
        .in(x_stall_q), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst), .out(m_stall_q)
    );

    Nbit_reg #(.n(2), .r(STALL_FLUSH)) u_w_stall (
        .in(m_stall_q), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst), .out(w_stall_q)
    );

    assign x_stall    = x_stall_q;
    assign m_stall    = m_stall_q;
    assign w_stall    = w_stall_q;
    assign test_stall = w_stall_q;

    lc4_sat_counter #(.W(CNT_W)) u_cnt_loaduse (
        .clk(clk), .rst(rst), .gwe(gwe),
        .inc(load_use && !x_redirect), .count(n_loaduse)
    );

    lc4_sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk(clk), .rst(rst), .gwe(gwe),
        .inc(x_redirect), .count(n_flush)
    );

endmodule

// File: tb/tb_lc4_pipe_ctrl.sv
// Bench for lc4_pipe_ctrl: combinational vector table, directed corner
// sequences, and randomized traffic against a pipeline reference model.
module tb_lc4_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, gwe;
    logic [2:0]  d_r1sel, d_r2sel, x_wsel;
    logic        d_r1re, d_r2re, d_is_store, d_is_branch;
    logic        x_is_load, x_regfile_we, x_redirect;
    logic        pc_we, fd_we, dx_bubble, fd_flush;
    logic [1:0]  x_stall, m_stall, w_stall, test_stall;
    logic [15:0] n_loaduse, n_flush;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stall code per instruction slot D, X, M, W.
    int codes [4];
    int ref_nlu, ref_nfl;

    always #5 clk = ~clk;

    lc4_pipe_ctrl dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .d_r1sel(d_r1sel), .d_r2sel(d_r2sel),
        .d_r1re(d_r1re), .d_r2re(d_r2re),
        .d_is_store(d_is_store), .d_is_branch(d_is_branch),
        .x_is_load(x_is_load), .x_regfile_we(x_regfile_we),
        .x_wsel(x_wsel), .x_redirect(x_redirect),
        .pc_we(pc_we), .fd_we(fd_we), .dx_bubble(dx_bubble), .fd_flush(fd_flush),
        .x_stall(x_stall), .m_stall(m_stall), .w_stall(w_stall),
        .test_stall(test_stall), .n_loaduse(n_loaduse), .n_flush(n_flush)
    );

    typedef struct {
        logic [2:0] r1sel, r2sel, wsel;
        logic       r1re, r2re, st, br, ld, rwe, redir;
        logic       e_pc_we, e_fd_we, e_bubble, e_flush;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit ref_lu();
        bit hit;
        hit = 0;
        if (d_r1re && d_r1sel == x_wsel) hit = 1;
        if (d_r2re && d_r2sel == x_wsel && !d_is_store) hit = 1;
        if (d_is_branch) hit = 1;
        return x_is_load && x_regfile_we && hit;
    endfunction

    task automatic clear_inputs();
        d_r1sel = 0; d_r2sel = 0; x_wsel = 0;
        d_r1re = 0; d_r2re = 0; d_is_store = 0; d_is_branch = 0;
        x_is_load = 0; x_regfile_we = 0; x_redirect = 0;
    endtask

    task automatic chk_comb();
        bit lu;
        lu = ref_lu();
        chk("pc_we",     pc_we,     (x_redirect || !lu) ? 1 : 0);
        chk("fd_we",     fd_we,     (x_redirect || !lu) ? 1 : 0);
        chk("dx_bubble", dx_bubble, (x_redirect || lu) ? 1 : 0);
        chk("fd_flush",  fd_flush,  x_redirect ? 1 : 0);
    endtask

    // Advance the model with the current inputs, clock once, then compare.
    task automatic tick(input bit do_chk);
        bit lu;
        int nd, nx;
        lu = ref_lu();
        if (rst) begin
            for (int i = 0; i < 4; i++) codes[i] = 2;
            ref_nlu = 0;
            ref_nfl = 0;
        end else if (gwe) begin
            nx = x_redirect ? 2 : (lu ? 3 : codes[0]);
            nd = x_redirect ? 2 : (lu ? codes[0] : 0);
            codes[3] = codes[2];
            codes[2] = codes[1];
            codes[1] = nx;
            codes[0] = nd;
            if (lu && !x_redirect && ref_nlu < 65535) ref_nlu++;
            if (x_redirect && ref_nfl < 65535) ref_nfl++;
        end
        @(posedge clk);
        #1;
        if (do_chk) begin
            chk("x_stall", x_stall, codes[1]);
            chk("m_stall", m_stall, codes[2]);
            chk("w_stall", w_stall, codes[3]);
            chk("test_stall", test_stall, codes[3]);
            chk("n_loaduse", n_loaduse, ref_nlu);
            chk("n_flush", n_flush, ref_nfl);
        end
    endtask

    task automatic do_reset();
        rst = 1; gwe = 0;
        tick(1);
        rst = 0;
    endtask

    task automatic set_load_use();
        clear_inputs();
        x_is_load = 1; x_regfile_we = 1; x_wsel = 3; d_r1re = 1; d_r1sel = 3;
    endtask

    task automatic add(input logic [2:0] r1sel, input logic r1re, input logic [2:0] r2sel,
                       input logic r2re, input logic st, input logic br, input logic ld,
                       input logic rwe, input logic [2:0] wsel, input logic redir,
                       input logic epc, input logic efd, input logic ebub, input logic efl);
        vec_t v;
        v.r1sel = r1sel; v.r1re = r1re; v.r2sel = r2sel; v.r2re = r2re;
        v.st = st; v.br = br; v.ld = ld; v.rwe = rwe; v.wsel = wsel; v.redir = redir;
        v.e_pc_we = epc; v.e_fd_we = efd; v.e_bubble = ebub; v.e_flush = efl;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1; gwe = 0;
        clear_inputs();
        #2;

        // Reset and drain: w_stall shows 2 for three edges, then 0.
        do_reset();
        chk("rst_x_stall", x_stall, 2);
        chk("rst_w_stall", w_stall, 2);
        chk("rst_n_loaduse", n_loaduse, 0);
        chk("rst_n_flush", n_flush, 0);
        gwe = 1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("drain_w_stall", w_stall, (i < 3) ? 2 : 0);
        end
        chk("drain_counters", n_loaduse + n_flush, 0);

        // Combinational vector table, state frozen with gwe=0.
        //   r1sel r1re r2sel r2re st br ld rwe wsel redir | pc fd bub fl
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(3, 1, 0, 0, 0, 0, 1, 1, 3, 0,  0, 0, 1, 0);
        add(3, 0, 0, 0, 0, 0, 1, 1, 3, 0,  1, 1, 0, 0);
        add(0, 0, 3, 1, 1, 0, 1, 1, 3, 0,  1, 1, 0, 0);
        add(0, 0, 3, 1, 0, 0, 1, 1, 3, 0,  0, 0, 1, 0);
        add(1, 1, 2, 1, 0, 1, 1, 1, 5, 0,  0, 0, 1, 0);
        add(3, 1, 0, 0, 0, 0, 1, 0, 3, 0,  1, 1, 0, 0);
        add(3, 1, 0, 0, 0, 0, 1, 1, 3, 1,  1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 1);
        add(2, 1, 4, 1, 0, 0, 1, 1, 3, 0,  1, 1, 0, 0);
        add(7, 1, 7, 1, 1, 0, 1, 1, 7, 0,  0, 0, 1, 0);
        gwe = 0;
        foreach (tbl[i]) begin
            d_r1sel = tbl[i].r1sel; d_r1re = tbl[i].r1re;
            d_r2sel = tbl[i].r2sel; d_r2re = tbl[i].r2re;
            d_is_store = tbl[i].st; d_is_branch = tbl[i].br;
            x_is_load = tbl[i].ld; x_regfile_we = tbl[i].rwe;
            x_wsel = tbl[i].wsel; x_redirect = tbl[i].redir;
            #1;
            chk($sformatf("vec%0d_pc_we", i), pc_we, tbl[i].e_pc_we);
            chk($sformatf("vec%0d_fd_we", i), fd_we, tbl[i].e_fd_we);
            chk($sformatf("vec%0d_bubble", i), dx_bubble, tbl[i].e_bubble);
            chk($sformatf("vec%0d_flush", i), fd_flush, tbl[i].e_flush);
            tick(1);
        end

        // Load-use: bubble, X code 3, reaches W two edges later.
        do_reset();
        gwe = 1;
        set_load_use();
        #1;
        chk("lu_pc_we", pc_we, 0);
        chk("lu_fd_we", fd_we, 0);
        chk("lu_bubble", dx_bubble, 1);
        tick(1);
        chk("lu_x_stall", x_stall, 3);
        chk("lu_n_loaduse", n_loaduse, 1);
        clear_inputs();
        tick(1);
        tick(1);
        chk("lu_w_stall", w_stall, 3);

        // Store data operand does not stall.
        do_reset();
        gwe = 1;
        clear_inputs();
        x_is_load = 1; x_regfile_we = 1; x_wsel = 3;
        d_r2re = 1; d_r2sel = 3; d_is_store = 1;
        #1;
        chk("st_pc_we", pc_we, 1);
        chk("st_bubble", dx_bubble, 0);
        tick(1);
        chk("st_n_loaduse", n_loaduse, 0);
        chk("st_x_stall", x_stall, 2);

        // Redirect coinciding with load-use: flush wins.
        do_reset();
        gwe = 1;
        set_load_use();
        x_redirect = 1;
        #1;
        chk("sim_flush", fd_flush, 1);
        chk("sim_pc_we", pc_we, 1);
        tick(1);
        chk("sim_x_stall", x_stall, 2);
        chk("sim_n_flush", n_flush, 1);
        chk("sim_n_loaduse", n_loaduse, 0);

        // Consecutive load-use with gwe held low for five clocks.
        do_reset();
        gwe = 1;
        set_load_use();
        tick(1);
        tick(1);
        chk("cons_n_loaduse", n_loaduse, 2);
        gwe = 0;
        for (int i = 0; i < 5; i++) tick(1);
        chk("hold_x_stall", x_stall, 3);
        chk("hold_m_stall", m_stall, 3);
        chk("hold_w_stall", w_stall, 2);
        chk("hold_n_loaduse", n_loaduse, 2);
        chk("hold_bubble", dx_bubble, 1);

        // Reset during a stall and a flush overrides everything.
        gwe = 1; rst = 1; x_redirect = 1;
        tick(1);
        rst = 0;
        chk("midrst_x_stall", x_stall, 2);
        chk("midrst_m_stall", m_stall, 2);
        chk("midrst_n_loaduse", n_loaduse, 0);
        chk("midrst_n_flush", n_flush, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            d_r1sel = 3'($urandom_range(0, 3));
            d_r2sel = 3'($urandom_range(0, 3));
            x_wsel  = 3'($urandom_range(0, 3));
            d_r1re = 1'($urandom); d_r2re = 1'($urandom);
            d_is_store = 1'($urandom); d_is_branch = ($urandom_range(0, 7) == 0);
            x_is_load = 1'($urandom); x_regfile_we = ($urandom_range(0, 3) != 0);
            x_redirect = ($urandom_range(0, 5) == 0);
            gwe = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            chk_comb();
            tick(1);
        end
        rst = 0;

        // Saturation of the load-use counter.
        do_reset();
        gwe = 1;
        set_load_use();
        for (int i = 0; i < 65540; i++) tick(i >= 65530);
        chk("sat_n_loaduse", n_loaduse, 16'hFFFF);
        tick(1);
        chk("sat_hold", n_loaduse, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
